// File: rtl/regfile_write_arbiter_pkg.sv
// Shared CPU definitions used by the register-file write arbiter:
// register geometry, the arbiter FSM states and the write payload.
package regfile_write_arbiter_pkg;

    localparam int unsigned REGISTER_WIDTH = 32;
    localparam int unsigned REGISTER_DEPTH = 32;
    localparam int unsigned REG_ADDR_W     = $clog2(REGISTER_DEPTH);

    typedef enum logic [0:0] {
        ARB_NORMAL = 1'b0,
        ARB_DRAIN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]     address;
        logic [REGISTER_WIDTH-1:0] data;
    } rf_write_t;

endpackage

// File: rtl/regfile_write_arbiter_sync_fifo.sv
// Synchronous FIFO holding buffered long-latency results; first-word
// fall-through read of the head entry, pointers wrap modulo DEPTH.
module sync_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  rf_write_t                  push_data,
    input  logic                       pop,
    output rf_write_t                  pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rf_write_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage and buffered long-latency results, with starvation hold.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_enable,
    input  logic [REG_ADDR_W-1:0]           wb_address,
    input  logic [REGISTER_WIDTH-1:0]       wb_data,
    input  logic                            lu_tvalid,
    output logic                            lu_tready,
    input  logic [REG_ADDR_W-1:0]           lu_address,
    input  logic [REGISTER_WIDTH-1:0]       lu_data,
    output logic                            rf_enable,
    output logic [REG_ADDR_W-1:0]           rf_address,
    output logic [REGISTER_WIDTH-1:0]       rf_data,
    output logic                            wb_hold,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] pending_count
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] NORMAL = ARB_NORMAL;
    localparam logic [0:0] DRAIN  = ARB_DRAIN;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_next;

    logic          wb_grant;
    logic          lu_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    rf_write_t     fifo_in;
    rf_write_t     fifo_head;

    // Address 0 is the hardwired zero register: never written, never buffered.
    always_comb begin
        wb_grant = wb_enable && (wb_address != '0);
        lu_push  = lu_tvalid && lu_tready && (lu_address != '0);
        fifo_pop = !fifo_empty && !wb_grant;
    end

    assign lu_tready       = !rst && !fifo_full;
    assign fifo_in.address = lu_address;
    assign fifo_in.data    = lu_data;
    assign wb_hold         = (state == DRAIN);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lu_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Starvation counting and NORMAL/DRAIN transitions.
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;

        if (fifo_empty || fifo_pop) begin
            starve_next = '0;
        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_next = starve_cnt + SW'(1);
        end

        if (state == NORMAL) begin
            if ((starve_cnt == SW'(STARVE_LIMIT)) && !fifo_pop) begin
                state_next = DRAIN;
            end
        end else begin
            if (fifo_pop) begin
                state_next = NORMAL;
            end
        end
    end

    // Registered register-file write port; pipeline write has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_enable  <= 1'b0;
            rf_address <= '0;
            rf_data    <= '0;
        end else begin
            rf_enable <= wb_grant || fifo_pop;
            if (wb_grant) begin
                rf_address <= wb_address;
                rf_data    <= wb_data;
            end else if (fifo_pop) begin
                rf_address <= fifo_head.address;
                rf_data    <= fifo_head.data;
            end else begin
                rf_address <= '0;
                rf_data    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      wb_enable;
    logic [REG_ADDR_W-1:0]     wb_address;
    logic [REGISTER_WIDTH-1:0] wb_data;
    logic                      lu_tvalid;
    logic                      lu_tready;
    logic [REG_ADDR_W-1:0]     lu_address;
    logic [REGISTER_WIDTH-1:0] lu_data;
    logic                      rf_enable;
    logic [REG_ADDR_W-1:0]     rf_address;
    logic [REGISTER_WIDTH-1:0] rf_data;
    logic                      wb_hold;
    logic [CW-1:0]             pending_count;

    int total = 0;
    int bad   = 0;

    rf_write_t mq[$];
    int        m_starve = 0;
    bit        m_drain  = 1'b0;
    bit        e_en     = 1'b0;
    rf_write_t e_wr;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_enable     (wb_enable),
        .wb_address    (wb_address),
        .wb_data       (wb_data),
        .lu_tvalid     (lu_tvalid),
        .lu_tready     (lu_tready),
        .lu_address    (lu_address),
        .lu_data       (lu_data),
        .rf_enable     (rf_enable),
        .rf_address    (rf_address),
        .rf_data       (rf_data),
        .wb_hold       (wb_hold),
        .pending_count (pending_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check ready, advance the model, check outputs.
    task automatic step(input bit r, input bit wen, input int waddr, input logic [31:0] wdata,
                        input bit lv, input int laddr, input logic [31:0] ldata);
        bit        ready;
        bit        wbw;
        bit        pop;
        int        sz;
        rf_write_t beat;
        rst        = r;
        wb_enable  = wen;
        wb_address = REG_ADDR_W'(waddr);
        wb_data    = wdata;
        lu_tvalid  = lv;
        lu_address = REG_ADDR_W'(laddr);
        lu_data    = ldata;
        #1;
        ready = !r && (mq.size() < DEPTH);
        chk("lu_tready", 64'(lu_tready), 64'(ready));

        if (r) begin
            mq.delete();
            m_starve = 0;
            m_drain  = 1'b0;
            e_en     = 1'b0;
        end else begin
            sz   = mq.size();
            wbw  = wen && (waddr != 0);
            pop  = !wbw && (sz > 0);
            e_en = wbw || pop;
            if (wbw) begin
                e_wr.address = REG_ADDR_W'(waddr);
                e_wr.data    = wdata;
            end else if (pop) begin
                e_wr = mq[0];
            end
            if (!m_drain && (m_starve == LIMIT) && !pop) m_drain = 1'b1;
            else if (m_drain && pop)                      m_drain = 1'b0;
            if (sz == 0 || pop) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (pop) void'(mq.pop_front());
            if (lv && ready && (laddr != 0)) begin
                beat.address = REG_ADDR_W'(laddr);
                beat.data    = ldata;
                mq.push_back(beat);
            end
        end

        @(posedge clk);
        #1;
        chk("rf_enable", 64'(rf_enable), 64'(e_en));
        if (e_en) begin
            chk("rf_address", 64'(rf_address), 64'(e_wr.address));
            chk("rf_data", 64'(rf_data), 64'(e_wr.data));
        end
        chk("wb_hold", 64'(wb_hold), 64'(m_drain));
        chk("pending_count", 64'(pending_count), 64'(mq.size()));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        chk("reset_rf_address", 64'(rf_address), 64'h0);
        chk("reset_rf_data", 64'(rf_data), 64'h0);

        // Plain pipeline write
        step(1'b0, 1'b1, 5, 32'hA5A5_A5A5, 1'b0, 0, 32'h0);
        chk("wb_only_en", 64'(rf_enable), 64'h1);
        chk("wb_only_addr", 64'(rf_address), 64'h5);
        chk("wb_only_data", 64'(rf_data), 64'hA5A5_A5A5);
        chk("wb_only_hold", 64'(wb_hold), 64'h0);
        idle();

        // Long-latency beat with idle writeback: buffered, then written
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 7, 32'h12);
        chk("lu_pending", 64'(pending_count), 64'h1);
        chk("lu_no_bypass", 64'(rf_enable), 64'h0);
        idle();
        chk("lu_write_addr", 64'(rf_address), 64'h7);
        chk("lu_write_data", 64'(rf_data), 64'h12);
        idle();

        // Zero-register traffic is dropped
        step(1'b0, 1'b1, 0, 32'hDEAD, 1'b1, 0, 32'hBEEF);
        chk("zero_pending", 64'(pending_count), 64'h0);
        chk("zero_no_write", 64'(rf_enable), 64'h0);
        idle();

        // Starvation: buffer fills, pipeline is held, then drains
        step(1'b0, 1'b1, 3, 32'h33, 1'b1, 9, 32'h11);
        step(1'b0, 1'b1, 4, 32'h44, 1'b1, 10, 32'h22);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 20 + i, 32'(i), 1'b0, 0, 32'h0);
        chk("starve_hold", 64'(wb_hold), 64'h1);
        chk("starve_full_ready", 64'(lu_tready), 64'h0);
        idle();
        chk("drain_write_addr", 64'(rf_address), 64'h9);
        chk("drain_release", 64'(wb_hold), 64'h0);
        chk("drain_ready", 64'(lu_tready), 64'h1);
        idle();
        idle();

        // Full buffer with simultaneous pop and valid; order across wrap
        step(1'b0, 1'b1, 2, 32'h2, 1'b1, 11, 32'hB1);
        step(1'b0, 1'b1, 2, 32'h2, 1'b1, 12, 32'hB2);
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 13, 32'hB3);
        chk("full_pop_not_taken", 64'(pending_count), 64'h1);
        chk("full_pop_head", 64'(rf_address), 64'd11);
        step(1'b0, 1'b0, 0, 32'h0, 1'b1, 13, 32'hB3);
        chk("wrap_second", 64'(rf_address), 64'd12);
        idle();
        chk("wrap_third", 64'(rf_address), 64'd13);
        idle();

        // Reset with two pending entries discards them
        step(1'b0, 1'b1, 1, 32'h1, 1'b1, 14, 32'hC1);
        step(1'b0, 1'b1, 1, 32'h1, 1'b1, 15, 32'hC2);
        chk("pre_reset_pending", 64'(pending_count), 64'h2);
        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
        chk("mid_reset_pending", 64'(pending_count), 64'h0);
        idle();
        chk("post_reset_no_write", 64'(rf_enable), 64'h0);
        idle();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(99) < 55),
                 ($urandom_range(7) == 0) ? 0 : int'($urandom_range(31)),
                 $urandom,
                 ($urandom_range(99) < 60),
                 ($urandom_range(7) == 0) ? 0 : int'($urandom_range(31)),
                 $urandom);
        end
        for (int i = 0; i < 4; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL take parameter STARVE_LIMIT, default 4, meaning consecutive cycles a buffered long-latency result may lose arbitration before the pipeline is held.
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 2, meaning the number of entries in the long-latency result buffer.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wb_enable  input  1  pipeline writeback stage requests a register write this cycle; never back-pressured.
REQ-006 wb_address  input  $clog2(REGISTER_DEPTH)  destination register of the pipeline write.
REQ-007 wb_data  input  REGISTER_WIDTH  pipeline write data.
REQ-008 lu_tvalid  input  1  long-latency unit (mul/div) result valid.
REQ-009 lu_tready  output  1  arbiter can accept a long-latency result.
REQ-010 lu_address  input  $clog2(REGISTER_DEPTH)  long-latency result destination register.
REQ-011 lu_data  input  REGISTER_WIDTH  long-latency result data.
REQ-012 rf_enable / rf_address / rf_data  output  1 / $clog2(REGISTER_DEPTH) / REGISTER_WIDTH  registered register-file write port.
REQ-013 wb_hold  output  1  registered request that the pipeline present wb_enable=0 next cycle.
REQ-014 pending_count  output  $clog2(FIFO_DEPTH+1)  current buffer occupancy.

Function
REQ-015 A long-latency beat SHALL be accepted exactly when lu_tvalid && lu_tready; lu_tready SHALL equal !full, with no same-cycle bypass from a pop.
REQ-016 Accepted beats with lu_address==0 SHALL be consumed and discarded, not enqueued.
REQ-017 Accepted beats with nonzero address SHALL enqueue in FIFO order; the buffer pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; a beat SHALL never bypass the buffer (earliest grant is the cycle after acceptance).
REQ-019 Grant per cycle: wb_enable && wb_address!=0 wins; otherwise a non-empty buffer head is granted and popped; otherwise no write.
REQ-020 wb_enable with wb_address==0 SHALL produce no write and SHALL NOT block a buffer grant.
REQ-021 The granted write SHALL appear on rf_enable/rf_address/rf_data on the next rising edge (1-cycle latency); rf_enable SHALL be 0 in any cycle following no grant.
REQ-022 Writes SHALL be issued in grant order; WAW ordering between requesters is the issue stage's responsibility.
REQ-023 starve_cnt SHALL increment, saturating at STARVE_LIMIT, each cycle the buffer is non-empty and not granted, and SHALL clear on any pop or when the buffer is empty.
REQ-024 The FSM SHALL have states NORMAL and DRAIN; NORMAL->DRAIN when starve_cnt reaches STARVE_LIMIT; DRAIN->NORMAL on the cycle a pop occurs.
REQ-025 wb_hold SHALL be 1 exactly while in DRAIN.
REQ-026 If wb_enable is asserted while in DRAIN, the pipeline write SHALL still win, so data is never lost, and the FSM SHALL remain in DRAIN.

Reset
REQ-027 While rst is high, rf_enable, rf_address, rf_data, wb_hold, lu_tready and pending_count SHALL be 0, the FSM SHALL be NORMAL, and starve_cnt SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries; lu_tready SHALL become 1 on the first cycle after rst deasserts.

Structure
REQ-029 REGISTER_WIDTH and REGISTER_DEPTH SHALL come from the shared CPU package, and the FSM state enum SHALL be added to that package.
REQ-030 The buffer SHALL be a separate sub-module, sync_fifo, with push/pop/full/empty/count ports; the arbitration logic and FSM SHALL live in regfile_write_arbiter.

Verification
REQ-031 Only wb_enable=1, wb_address=5, wb_data=0xA5A5A5A5 in cycle N -> rf_enable=1, rf_address=5, rf_data=0xA5A5A5A5 in cycle N+1, and wb_hold=0.
REQ-032 lu beat (address 7, data 0x12) accepted in cycle N with wb idle -> pending_count=1 in cycle N+1, then rf write of address 7, data 0x12 in cycle N+2.
REQ-033 Two lu beats back to back with wb_enable=1 continuously -> lu_tready=0 after the second beat, starve_cnt reaches 4, wb_hold=1; when wb_enable drops, the head is written, wb_hold returns to 0, and lu_tready returns to 1.
REQ-034 lu beat with address 0, and wb_enable with address 0 -> no rf write and pending_count stays 0.
REQ-035 rst asserted for 1 cycle with pending_count=2 -> no rf write of those entries and pending_count=0; lu_tready=1 on the cycle after rst deasserts.
REQ-036 Buffer full with a pop and an lu_tvalid in the same cycle -> the beat is not accepted that cycle (lu_tready=0), is accepted the next cycle, and FIFO order is preserved across pointer wrap.
